// File: rtl/data_cache_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the memory stage and a word-wide memory port.
// Latency: load hits return on o_DataOut one edge after acceptance; misses stall through writeback and refill.
// Backpressure: o_Stall holds the CPU while the line FSM waits on i_MemAck, one word per handshake.
module data_cache_dm #(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_ReadEnable,
  input  logic        i_WriteEnable,
  input  logic [2:0]  i_Mode,
  input  logic [31:0] i_Address,
  input  logic [31:0] i_DataIn,
  output logic [31:0] o_DataOut,
  output logic        o_Stall,
  output logic        o_MisalignedAccess,
  output logic        o_MemReq,
  output logic        o_MemWrite,
  output logic [31:0] o_MemAddr,
  output logic [31:0] o_MemWriteData,
  input  logic        i_MemAck,
  input  logic [31:0] i_MemReadData
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - 2 - WORD_W - IDX_W;
  localparam int LINE_W = IDX_W + WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t            state;
  logic [WORD_W-1:0] wordCnt;
  logic [WORD_W-1:0] nextCnt;

  logic [SETS-1:0]   lineValid;
  logic [SETS-1:0]   lineDirty;
  logic [TAG_W-1:0]  lineTag [SETS];
  logic [31:0]       dataArr [SETS*WORDS_PER_LINE];

  logic [1:0]        reqOffset;
  logic [WORD_W-1:0] reqWord;
  logic [IDX_W-1:0]  reqIndex;
  logic [TAG_W-1:0]  reqTag;

  logic isStore, isActive, modeValid, isHalf, isWord;
  logic misaligned, accept, hit, doStore;
  logic [31:0] hitWord, loadData, storeLanes;
  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic [3:0]  byteEn;

  assign reqOffset = i_Address[1:0];
  assign reqWord   = i_Address[2 +: WORD_W];
  assign reqIndex  = i_Address[2+WORD_W +: IDX_W];
  assign reqTag    = i_Address[31 -: TAG_W];
  assign nextCnt   = wordCnt + 1'b1;

  // Store wins when both enables are set; BU/HU are only legal for loads.
  assign isStore  = i_WriteEnable;
  assign isActive = i_WriteEnable | i_ReadEnable;
  assign isHalf   = (i_Mode[1:0] == 2'b01);
  assign isWord   = (i_Mode[1:0] == 2'b10);

  // Classify the mode; illegal encodings behave as if no request were made.
  always_comb begin
    modeValid = 1'b0;
    case (i_Mode)
      3'b000, 3'b001, 3'b010: modeValid = 1'b1;
      3'b100, 3'b101:         modeValid = ~isStore;
      default:                modeValid = 1'b0;
    endcase
  end

  assign misaligned = isActive && modeValid &&
                      ((isHalf && reqOffset[0]) || (isWord && (reqOffset != 2'b00)));
  assign accept     = isActive && modeValid && !misaligned;
  assign hit        = lineValid[reqIndex] && (lineTag[reqIndex] == reqTag);
  assign doStore    = (state == IDLE) && accept && hit && isStore;

  assign o_MisalignedAccess = misaligned;
  assign o_Stall            = (state != IDLE) || (accept && !hit);

  assign hitWord = dataArr[{reqIndex, reqWord}];
  assign selByte = hitWord[{reqOffset, 3'b000} +: 8];
  assign selHalf = reqOffset[1] ? hitWord[31:16] : hitWord[15:0];

  // Extract and extend the addressed lane for a load hit.
  always_comb begin
    loadData = hitWord;
    case (i_Mode)
      3'b000:  loadData = {{24{selByte[7]}}, selByte};
      3'b001:  loadData = {{16{selHalf[15]}}, selHalf};
      3'b100:  loadData = {24'h0, selByte};
      3'b101:  loadData = {16'h0, selHalf};
      default: loadData = hitWord;
    endcase
  end

  // Replicate right-aligned store data across lanes and pick the lanes to write.
  always_comb begin
    byteEn     = 4'b1111;
    storeLanes = i_DataIn;
    case (i_Mode[1:0])
      2'b00: begin
        byteEn     = 4'b0001 << reqOffset;
        storeLanes = {4{i_DataIn[7:0]}};
      end
      2'b01: begin
        byteEn     = reqOffset[1] ? 4'b1100 : 4'b0011;
        storeLanes = {2{i_DataIn[15:0]}};
      end
      default: begin
        byteEn     = 4'b1111;
        storeLanes = i_DataIn;
      end
    endcase
  end

  // Data array: refill words land from memory, store hits merge byte lanes; never reset.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      if (state == REFILL && i_MemAck) begin
        dataArr[LINE_W'({reqIndex, wordCnt})] <= i_MemReadData;
      end else if (doStore) begin
        for (int b = 0; b < 4; b++) begin
          if (byteEn[b]) dataArr[LINE_W'({reqIndex, reqWord})][b*8 +: 8] <= storeLanes[b*8 +: 8];
        end
      end
    end
  end

  // Line FSM: serves hits in IDLE, otherwise writes back a dirty victim then refills the line.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= IDLE;
      wordCnt        <= '0;
      lineValid      <= '0;
      lineDirty      <= '0;
      o_DataOut      <= '0;
      o_MemReq       <= 1'b0;
      o_MemWrite     <= 1'b0;
      o_MemAddr      <= '0;
      o_MemWriteData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && hit) begin
            if (isStore) lineDirty[reqIndex] <= 1'b1;
            else         o_DataOut <= loadData;
          end else if (accept) begin
            wordCnt  <= '0;
            o_MemReq <= 1'b1;
            if (lineValid[reqIndex] && lineDirty[reqIndex]) begin
              state          <= WRITEBACK;
              o_MemWrite     <= 1'b1;
              o_MemAddr      <= {lineTag[reqIndex], reqIndex, ZERO_WORD, 2'b00};
              o_MemWriteData <= dataArr[{reqIndex, ZERO_WORD}];
            end else begin
              state      <= REFILL;
              o_MemWrite <= 1'b0;
              o_MemAddr  <= {reqTag, reqIndex, ZERO_WORD, 2'b00};
            end
          end
        end
        WRITEBACK: begin
          if (i_MemAck) begin
            wordCnt <= nextCnt;
            if (wordCnt == LAST_WORD) begin
              state      <= REFILL;
              o_MemWrite <= 1'b0;
              o_MemAddr  <= {reqTag, reqIndex, ZERO_WORD, 2'b00};
            end else begin
              o_MemAddr      <= {lineTag[reqIndex], reqIndex, nextCnt, 2'b00};
              o_MemWriteData <= dataArr[{reqIndex, nextCnt}];
            end
          end
        end
        REFILL: begin
          if (i_MemAck) begin
            wordCnt <= nextCnt;
            if (wordCnt == LAST_WORD) begin
              state               <= IDLE;
              o_MemReq            <= 1'b0;
              lineValid[reqIndex] <= 1'b1;
              lineDirty[reqIndex] <= 1'b0;
              lineTag[reqIndex]   <= reqTag;
            end else begin
              o_MemAddr <= {reqTag, reqIndex, nextCnt, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_dm.sv
// Bench for data_cache_dm: directed scenarios then random loads/stores against a flat-memory reference.
// The reference tracks architectural memory contents plus which line each set holds to predict traffic.
// Backing memory responds with a programmable per-word acknowledge delay.
module tb_data_cache_dm;

  localparam int MEM_WORDS = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        readEnable = 1'b0;
  logic        writeEnable = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [31:0] address = '0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic        stall, misalignedAccess;
  logic        memReq, memWrite;
  logic [31:0] memAddr, memWriteData;
  logic        memAck = 1'b0;
  logic [31:0] memReadData = '0;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] bkMem  [MEM_WORDS];
  logic [31:0] refMem [MEM_WORDS];
  logic        mValid [64];
  logic        mDirty [64];
  int          mTag   [64];
  logic [31:0] lastDout = '0;

  int          ackDelay = 0;
  int          waitCnt = 0;
  logic [31:0] waitAddr = '0;
  int          protoErrors = 0;
  logic [31:0] logAddr [$];
  logic        logWr   [$];
  logic [31:0] logData [$];

  data_cache_dm #(.SETS(64), .WORDS_PER_LINE(4)) dut (
    .i_Clock(clock), .i_Reset(reset),
    .i_ReadEnable(readEnable), .i_WriteEnable(writeEnable),
    .i_Mode(mode), .i_Address(address), .i_DataIn(dataIn),
    .o_DataOut(dataOut), .o_Stall(stall), .o_MisalignedAccess(misalignedAccess),
    .o_MemReq(memReq), .o_MemWrite(memWrite), .o_MemAddr(memAddr),
    .o_MemWriteData(memWriteData), .i_MemAck(memAck), .i_MemReadData(memReadData)
  );

  always #5 clock = ~clock;

  // Backing memory: acknowledges a held request after ackDelay waiting cycles.
  always @(negedge clock) begin
    memAck = 1'b0;
    if (memReq && !reset) begin
      if (memAddr[1:0] != 2'b00) protoErrors++;
      if (waitCnt > 0 && memAddr != waitAddr) protoErrors++;
      waitAddr = memAddr;
      if (waitCnt >= ackDelay) begin
        memAck = 1'b1;
        memReadData = bkMem[memAddr[13:2]];
        if (memWrite) bkMem[memAddr[13:2]] = memWriteData;
        logAddr.push_back(memAddr);
        logWr.push_back(memWrite);
        logData.push_back(memWriteData);
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] loadExpect(input logic [2:0] m, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = refMem[a[13:2]] >> (8 * int'(a[1:0]));
    b = w[7:0];
    h = w[15:0];
    case (m)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return refMem[a[13:2]];
    endcase
  endfunction

  task automatic storeRef(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    sh   = 8 * int'(a[1:0]);
    mask = (m[1:0] == 2'b00) ? 32'hFF : (m[1:0] == 2'b01) ? 32'hFFFF : 32'hFFFFFFFF;
    mask = mask << sh;
    refMem[a[13:2]] = (refMem[a[13:2]] & ~mask) | ((d << sh) & mask);
  endtask

  // Present one request and hold it until the cache accepts it.
  task automatic access(input logic we, input logic re, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] dout, output logic stallSeen,
                        output logic misSeen, output logic reqSeen);
    int cycles;
    logAddr.delete(); logWr.delete(); logData.delete();
    @(posedge clock); #1;
    writeEnable = we; readEnable = re; mode = m; address = a; dataIn = d;
    cycles = 0; stallSeen = 0; misSeen = 0; reqSeen = 0;
    forever begin
      @(negedge clock);
      misSeen |= misalignedAccess;
      reqSeen |= memReq;
      if (!stall) break;
      stallSeen = 1;
      cycles++;
      if (cycles > 500) begin
        checkVal("stall timeout", stall, 0);
        break;
      end
    end
    @(posedge clock); #1;
    dout = dataOut;
    writeEnable = 0; readEnable = 0;
  endtask

  // Run one request, predicting flags, memory traffic and load data from the reference.
  task automatic runOp(input logic we, input logic re, input logic [2:0] m,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] dout);
    int set, tag, nWr, nRd, expWr, expRd, firstRd;
    logic validMode, mis, accept, hit, stallSeen, misSeen, reqSeen;
    logic [31:0] expDout;
    set = int'(a[9:4]);
    tag = int'(a[31:10]);
    if (we) validMode = (m == 3'b000 || m == 3'b001 || m == 3'b010);
    else    validMode = (m == 3'b000 || m == 3'b001 || m == 3'b010 || m == 3'b100 || m == 3'b101);
    mis = (we || re) && validMode &&
          ((m[1:0] == 2'b01 && a[0]) || (m[1:0] == 2'b10 && a[1:0] != 2'b00));
    accept = (we || re) && validMode && !mis;
    hit    = mValid[set] && (mTag[set] == tag);
    expWr  = (accept && !hit && mValid[set] && mDirty[set]) ? 4 : 0;
    expRd  = (accept && !hit) ? 4 : 0;
    expDout = (accept && !we) ? loadExpect(m, a) : lastDout;

    access(we, re, m, a, d, dout, stallSeen, misSeen, reqSeen);

    checkVal("misaligned flag", misSeen, mis);
    checkVal("stall", stallSeen, accept && !hit);
    if (accept) begin
      nWr = 0; nRd = 0; firstRd = -1;
      for (int i = 0; i < logWr.size(); i++) begin
        if (logWr[i]) nWr++;
        else begin
          if (firstRd < 0) firstRd = i;
          nRd++;
        end
      end
      checkVal("writeback count", nWr, expWr);
      checkVal("refill count", nRd, expRd);
      if (expWr > 0 && logAddr.size() > 0)
        checkVal("victim addr", logAddr[0], (mTag[set] << 10) | (set << 4));
      if (firstRd >= 0)
        checkVal("refill addr", logAddr[firstRd], (tag << 10) | (set << 4));
      if (!hit) begin mValid[set] = 1; mTag[set] = tag; mDirty[set] = 0; end
      if (we) begin mDirty[set] = 1; storeRef(m, a, d); end
    end else begin
      checkVal("idle mem req", reqSeen, 0);
    end
    checkVal("dataOut", dout, expDout);
    lastDout = expDout;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int cycles;
    for (int i = 0; i < MEM_WORDS; i++) bkMem[i] = $urandom;
    bkMem[32'h40] = 32'h11111111; bkMem[32'h41] = 32'h22222222;
    bkMem[32'h42] = 32'h33333333; bkMem[32'h43] = 32'h44444444;
    for (int i = 0; i < MEM_WORDS; i++) refMem[i] = bkMem[i];
    for (int s = 0; s < 64; s++) begin mValid[s] = 0; mDirty[s] = 0; mTag[s] = 0; end

    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    checkVal("reset dataOut", dataOut, 0);
    checkVal("reset memReq", memReq, 0);
    checkVal("reset memWrite", memWrite, 0);
    checkVal("reset memAddr", memAddr, 0);
    checkVal("reset memWriteData", memWriteData, 0);
    checkVal("reset stall", stall, 0);

    // Cold load miss: four refill reads, then the first word.
    runOp(0, 1, 3'b010, 32'h100, 0, r);
    checkVal("LW 0x100", r, 32'h11111111);
    for (int i = 0; i < logAddr.size(); i++)
      checkVal($sformatf("cold refill addr %0d", i), logAddr[i], 32'h100 + 4 * i);

    // Byte store then loads with sign/zero extension.
    runOp(1, 0, 3'b000, 32'h101, 32'h80, r);
    runOp(0, 1, 3'b000, 32'h101, 0, r);
    checkVal("LB 0x101", r, 32'hFFFFFF80);
    runOp(0, 1, 3'b100, 32'h101, 0, r);
    checkVal("LBU 0x101", r, 32'h00000080);
    runOp(0, 1, 3'b010, 32'h100, 0, r);
    checkVal("LW after SB", r, 32'h11118011);

    // Conflict miss: dirty victim written back before the refill.
    runOp(0, 1, 3'b010, 32'h500, 0, r);
    for (int i = 0; i < logAddr.size(); i++) begin
      checkVal($sformatf("conflict addr %0d", i), logAddr[i],
               (i < 4) ? 32'h100 + 4 * i : 32'h500 + 4 * (i - 4));
      checkVal($sformatf("conflict dir %0d", i), logWr[i], (i < 4) ? 1 : 0);
    end
    if (logData.size() > 0) checkVal("first writeback data", logData[0], 32'h11118011);

    // Misaligned requests are flagged and have no effect.
    runOp(0, 1, 3'b010, 32'h102, 0, r);
    runOp(1, 0, 3'b001, 32'h103, 32'hBEEF, r);
    runOp(0, 1, 3'b101, 32'h102, 0, r);
    checkVal("LHU 0x102", r, 32'h00001111);

    // Slow memory: request and address must hold while waiting.
    ackDelay = 3;
    runOp(0, 1, 3'b010, 32'h20C, 0, r);
    ackDelay = 0;
    checkVal("memory protocol errors", protoErrors, 0);

    // Reset while the second refill word is outstanding.
    logAddr.delete(); logWr.delete(); logData.delete();
    @(posedge clock); #1;
    address = 32'h300; mode = 3'b010; readEnable = 1;
    cycles = 0;
    while (logAddr.size() < 1 && cycles < 50) begin
      @(negedge clock);
      cycles++;
    end
    checkVal("first refill ack seen", logAddr.size(), 1);
    @(posedge clock); #1 reset = 1;
    @(posedge clock);
    @(negedge clock);
    checkVal("memReq after reset", memReq, 0);
    checkVal("dataOut after reset", dataOut, 0);
    @(posedge clock); #1;
    reset = 0; readEnable = 0;
    for (int s = 0; s < 64; s++) begin mValid[s] = 0; mDirty[s] = 0; end
    for (int i = 0; i < MEM_WORDS; i++) refMem[i] = bkMem[i];
    lastDout = 0;
    runOp(0, 1, 3'b010, 32'h300, 0, r);
    checkVal("LW 0x300 after reset", r, bkMem[32'hC0]);

    // Random traffic concentrated on a few sets to force evictions.
    for (int n = 0; n < 400; n++) begin
      logic we, re;
      logic [2:0] m;
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      we = (sel >= 5);
      re = (sel >= 1 && sel <= 4) || sel == 9;
      case ($urandom_range(0, 11))
        0, 1:    m = 3'b000;
        2, 3:    m = 3'b001;
        4, 5, 6: m = 3'b010;
        7, 8:    m = 3'b100;
        9, 10:   m = 3'b101;
        default: m = 3'($urandom_range(0, 7));
      endcase
      a = ($urandom_range(0, 7) << 10) | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (m[1:0] == 2'b01) a[0] = 1'b0;
        if (m[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      ackDelay = $urandom_range(0, 2);
      runOp(we, re, m, a, $urandom, r);
    end
    checkVal("random protocol errors", protoErrors, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
